// File: rtl/md_pkg.sv
// Shared definitions for the EXE-stage multi-cycle divide unit.
package md_pkg;

  // Divider sequencer state encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PREP = ST_PREP,
    S_ITER = ST_ITER,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } div_state_e;

  // Bit positions inside the one-hot div_op (alu_op[18:15] order).
  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  // Quotient produced for a zero divisor is all-ones; replicate this fill bit to DW.
  localparam logic DIVZ_QUO_FILL = 1'b1;

  // Decoded operation: which result to return and whether operands are signed.
  typedef struct packed {
    logic is_mod;
    logic is_signed;
  } div_ctl_t;

  // Multi-hot encodings resolve to the lowest set bit.
  function automatic div_ctl_t decode_op(input logic [3:0] op);
    div_ctl_t c;
    c = '0;
    if (op[DIV_W]) begin
      c.is_mod = 1'b0; c.is_signed = 1'b1;
    end else if (op[MOD_W]) begin
      c.is_mod = 1'b1; c.is_signed = 1'b1;
    end else if (op[DIV_WU]) begin
      c.is_mod = 1'b0; c.is_signed = 1'b0;
    end else if (op[MOD_WU]) begin
      c.is_mod = 1'b1; c.is_signed = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_iter_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quo,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_nxt,
  output logic [DW-1:0] quo_nxt
);

  logic [DW:0] sh;

  // rem < divisor on entry, so the difference always fits back into DW bits.
  always_comb begin
    sh = {rem, quo[DW-1]};
    if (sh >= {1'b0, divisor}) begin
      rem_nxt = sh[DW-1:0] - divisor;
      quo_nxt = {quo[DW-2:0], 1'b1};
    end else begin
      rem_nxt = sh[DW-1:0];
      quo_nxt = {quo[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle signed/unsigned divide unit (DIV.W, MOD.W, DIV.WU, MOD.WU) for EXE.
module div_seq_unit
  import md_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    div_op,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          busy
);

  localparam int CNT_W = $clog2(DW) + 1;

  div_state_e     state_q, state_d;
  div_ctl_t       ctl_in;
  logic           mod_q, s1_q, s2_q;
  logic [DW-1:0]  a_q, b_q, rem_q, quo_q, dvs_q, result_q;
  logic [DW-1:0]  rem_n, quo_n, q_fix, r_fix;
  logic [CNT_W-1:0] cnt_q;
  logic           accept;

  assign ctl_in    = decode_op(div_op);
  assign accept    = in_valid & (state_q == S_IDLE) & (|div_op);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

  div_iter_step #(.DW(DW)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_n),
    .quo_nxt (quo_n)
  );

  // Sign fix-up: quotient sign is the XOR of operand signs, remainder follows the dividend.
  assign q_fix = (s1_q ^ s2_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fix = s1_q ? (~rem_q + 1'b1) : rem_q;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush beats everything, including a pending accept.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_PREP;
        S_PREP: state_d = (b_q == '0) ? S_DONE : S_ITER;
        S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand capture, magnitude prep, iteration and result fix-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mod_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mod_q <= ctl_in.is_mod;
            s1_q  <= ctl_in.is_signed & src1[DW-1];
            s2_q  <= ctl_in.is_signed & src2[DW-1];
            a_q   <= src1;
            b_q   <= src2;
          end
        end
        S_PREP: begin
          quo_q <= s1_q ? (~a_q + 1'b1) : a_q;
          dvs_q <= s2_q ? (~b_q + 1'b1) : b_q;
          rem_q <= '0;
          cnt_q <= CNT_W'(DW);
          // Zero divisor short-circuits straight to DONE with the architectural result.
          if (b_q == '0)
            result_q <= mod_q ? a_q : {DW{DIVZ_QUO_FILL}};
        end
        S_ITER: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          result_q <= mod_q ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: directed vectors, backpressure, abort and random ops.
module tb_div_seq_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    div_op = 4'd0;
  logic [DW-1:0] src1 = '0;
  logic [DW-1:0] src2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] result;
  logic          busy;

  div_seq_unit #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0] res;
    int            lat;
    int            acc;
    string         name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic truncates toward zero and has no INT_MIN/-1 trap.
  function automatic logic [DW-1:0] ref_div(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    bit     sgn, want_mod;
    longint sa, sd, q, r;
    logic [63:0] qv, rv;
    if (op[0])      begin sgn = 1; want_mod = 0; end
    else if (op[1]) begin sgn = 1; want_mod = 1; end
    else if (op[2]) begin sgn = 0; want_mod = 0; end
    else            begin sgn = 0; want_mod = 1; end
    if (b == 0) return want_mod ? a : {DW{1'b1}};
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sd = sgn ? longint'($signed(b)) : longint'(b);
    q = sa / sd;
    r = sa % sd;
    qv = q;
    rv = r;
    return want_mod ? rv[DW-1:0] : qv[DW-1:0];
  endfunction

  // Present an op at a negedge once the unit is ready; optionally register the expected result.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit push, input logic [DW-1:0] exp, input string nm);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout %s: in_ready stayed %b, required 1", nm, in_ready);
      return;
    end
    in_valid = 1'b1; div_op = op; src1 = a; src2 = b;
    if (push) begin
      e.res = exp; e.lat = (b == 0) ? 2 : DW + 3; e.acc = cyc; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: latency on the first out_valid cycle, result on the handshake cycle.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: out_valid=1 result=%h with nothing outstanding", result);
        end else begin
          chk_int({"latency ", sb[0].name}, cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        chk({"result ", sb[0].name}, result, sb[0].res);
        void'(sb.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    string         nm;
  } vec_t;

  vec_t dir[$];
  exp_t drop;

  initial begin
    int t;
    bit seen;
    logic [3:0]    rop;
    logic [DW-1:0] ra, rb;

    dir.push_back('{4'b0001, 32'd100,        32'd7,          32'd14,         "divw_100_7"});
    dir.push_back('{4'b0010, 32'd100,        32'd7,          32'd2,          "modw_100_7"});
    dir.push_back('{4'b0001, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "divw_m7_2"});
    dir.push_back('{4'b0010, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "modw_m7_2"});
    dir.push_back('{4'b0010, 32'd7,          32'hFFFFFFFE,   32'd1,          "modw_7_m2"});
    dir.push_back('{4'b0100, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   "divwu_max_16"});
    dir.push_back('{4'b1000, 32'hFFFFFFFF,   32'h10,         32'hF,          "modwu_max_16"});
    dir.push_back('{4'b0001, 32'hFFFFFFFF,   32'h10,         32'h0,          "divw_m1_16"});
    dir.push_back('{4'b0001, 32'd5,          32'd0,          32'hFFFFFFFF,   "divw_5_0"});
    dir.push_back('{4'b1000, 32'd5,          32'd0,          32'd5,          "modwu_5_0"});
    dir.push_back('{4'b0001, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "divw_ovf"});
    dir.push_back('{4'b0010, 32'h80000000,   32'hFFFFFFFF,   32'h0,          "modw_ovf"});

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(negedge clk) resetn = 1'b1;

    // Directed vectors with literal expectations
    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1, dir[i].exp, dir[i].nm);

    // div_op == 0 is ignored
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; div_op = 4'd0; src1 = 32'd9; src2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("zero_op_ignored_busy", busy, 0);

    // Backpressure: hold out_ready low in DONE with a second op waiting
    out_ready = 1'b0;
    issue(4'b0001, 32'd100, 32'd7, 1, 32'd14, "bp_divw");
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_reached_done", out_valid, 1);
    in_valid = 1'b1; div_op = 4'b1000; src1 = 32'd50; src2 = 32'd6;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_result_stable", result, 32'd14);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_after_ready", in_ready, 1);
    drop.res = 32'd2; drop.lat = DW + 3; drop.acc = cyc; drop.name = "bp_held_modwu";
    sb.push_back(drop);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_held_accepted", busy, 1);

    // Flush in the tenth ITER cycle
    issue(4'b0001, 32'd1000, 32'd3, 0, 0, "flushed");
    repeat (11) @(negedge clk);
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1; in_valid = 1'b1; div_op = 4'b0100; src1 = 32'd8; src2 = 32'd2;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", seen, 0);
    issue(4'b0100, 32'd9, 32'd3, 1, 32'd3, "divwu_9_3");

    // Async reset mid-ITER
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    issue(4'b0010, 32'd77, 32'd5, 0, 0, "reset_abort");
    repeat (8) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    @(negedge clk) resetn = 1'b1;

    // Random ops against the reference model, including multi-hot div_op
    for (int n = 0; n < 30; n++) begin
      rop = 4'($urandom_range(1, 15));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 0;
        1, 2:    rb = DW'($urandom_range(1, 20));
        3:       rb = {DW{1'b1}};
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 1) == 1) ra = DW'($signed(ra) >>> $urandom_range(0, 24));
      issue(rop, ra, rb, 1, ref_div(rop, ra, rb), $sformatf("rnd%0d_op%h", n, rop));
    end

    // Drain
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk_int("drain_outstanding", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
